// File: rtl/mem_stage_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu_pkg
// Description : Shared encodings for the memory-stage load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_lsu_pkg;

    localparam logic [1:0] c_load_sel = 2'b01;

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu_align
// Description : Store lane steering, load extract/extend, access legality.
// Revision    : 1.0 - initial release
// ============================================================================
import mem_stage_lsu_pkg::*;

module mem_stage_lsu_align #(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_wd,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [2:0]        i_funct3,
    input  logic              i_is_load,
    input  logic              i_is_store,
    output logic [3:0]        o_be,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_load_data,
    output logic              o_exc
);

    logic       w_illegal;
    logic       w_misalign;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        if (i_is_store)
            w_illegal = i_funct3[2] || (i_funct3[1:0] == 2'b11);
        else if (i_is_load)
            w_illegal = (i_funct3[1:0] == 2'b11) || (i_funct3[2:1] == 2'b11);
        case (i_funct3[1:0])
            2'b01:   w_misalign = i_addr_lo[0];
            2'b10:   w_misalign = (i_addr_lo != 2'b00);
            default: w_misalign = 1'b0;
        endcase
        o_exc = (i_is_load || i_is_store) && (w_illegal || w_misalign);
    end

    // Stores replicate data across lanes so the enables alone pick the target bytes.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wd;
        if (i_is_store) begin
            case (i_funct3[1:0])
                2'b00: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wd[7:0]}};
                end
                2'b01: begin
                    o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_wd[15:0]}};
                end
                default: begin
                    o_be    = 4'b1111;
                    o_wdata = i_wd;
                end
            endcase
        end
    end

    always_comb begin
        case (i_addr_lo)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            c_f3_b:  o_load_data = {{24{w_byte[7]}}, w_byte};
            c_f3_h:  o_load_data = {{16{w_half[15]}}, w_half};
            c_f3_bu: o_load_data = {24'd0, w_byte};
            c_f3_hu: o_load_data = {16'd0, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : Memory-stage LSU: req/gnt/rvalid port FSM and MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
import mem_stage_lsu_pkg::*;

module mem_stage_lsu #(
    parameter int         DATA_W   = 32,
    parameter int         PC_W     = 32,
    parameter int         ADDR_W   = 5,
    parameter logic [1:0] LOAD_SEL = c_load_sel
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_ALU_Res_M,
    input  logic [DATA_W-1:0] i_WriteData_M,
    input  logic [ADDR_W-1:0] i_Rd_M,
    input  logic [PC_W-1:0]   i_PCPlus4_M,
    input  logic [2:0]        i_Funct3_M,
    input  logic              i_RegWrite_M,
    input  logic [1:0]        i_ResultSrc_M,
    input  logic              i_MemWrite_M,
    output logic              o_Stall_M,
    output logic              o_MemExc_M,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [DATA_W-1:0] o_dmem_addr,
    output logic [DATA_W-1:0] o_dmem_wdata,
    output logic [3:0]        o_dmem_be,
    input  logic              i_dmem_gnt,
    input  logic              i_dmem_rvalid,
    input  logic [DATA_W-1:0] i_dmem_rdata,
    output logic [DATA_W-1:0] o_ALU_Res_W,
    output logic [DATA_W-1:0] o_ReadData_W,
    output logic [ADDR_W-1:0] o_Rd_W,
    output logic [PC_W-1:0]   o_PCPlus4_W,
    output logic              o_RegWrite_W,
    output logic [1:0]        o_ResultSrc_W
);

    lsu_state_t        r_state;
    lsu_state_t        w_next_state;
    logic              w_store;
    logic              w_load;
    logic              w_legal_op;
    logic              w_exc;
    logic              w_req;
    logic              w_stall;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_load_data;

    assign w_store    = i_MemWrite_M;
    assign w_load     = !i_MemWrite_M && (i_ResultSrc_M == LOAD_SEL);
    assign w_legal_op = (w_load || w_store) && !w_exc;

    mem_stage_lsu_align #(.DATA_W(DATA_W)) u_align (
        .i_addr_lo   (i_ALU_Res_M[1:0]),
        .i_wd        (i_WriteData_M),
        .i_rdata     (i_dmem_rdata),
        .i_funct3    (i_Funct3_M),
        .i_is_load   (w_load),
        .i_is_store  (w_store),
        .o_be        (w_be),
        .o_wdata     (o_dmem_wdata),
        .o_load_data (w_load_data),
        .o_exc       (w_exc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                w_req   = w_legal_op;
                w_stall = w_legal_op && !(w_store && i_dmem_gnt);
                if (w_legal_op && w_load && i_dmem_gnt)
                    w_next_state = RESP;
            end
            RESP: begin
                w_stall = !i_dmem_rvalid;
                if (i_dmem_rvalid)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Port controls are forced low while reset is held, not just after an edge.
    assign o_dmem_req  = rst && w_req;
    assign o_Stall_M   = rst && w_stall;
    assign o_MemExc_M  = rst && w_exc && (r_state == IDLE);
    assign o_dmem_we   = rst && w_store;
    assign o_dmem_be   = rst ? w_be : 4'b0000;
    assign o_dmem_addr = {i_ALU_Res_M[DATA_W-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || w_stall) begin
            o_ALU_Res_W   <= '0;
            o_ReadData_W  <= '0;
            o_Rd_W        <= '0;
            o_PCPlus4_W   <= '0;
            o_RegWrite_W  <= 1'b0;
            o_ResultSrc_W <= 2'b00;
        end else begin
            o_ALU_Res_W   <= i_ALU_Res_M;
            o_ReadData_W  <= (r_state == RESP) ? w_load_data : '0;
            o_Rd_W        <= i_Rd_M;
            o_PCPlus4_W   <= i_PCPlus4_M;
            o_RegWrite_W  <= i_RegWrite_M && !w_exc;
            o_ResultSrc_W <= i_ResultSrc_M;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Randomized self-checking bench for mem_stage_lsu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic [31:0] i_ALU_Res_M;
    logic [31:0] i_WriteData_M;
    logic [4:0]  i_Rd_M;
    logic [31:0] i_PCPlus4_M;
    logic [2:0]  i_Funct3_M;
    logic        i_RegWrite_M;
    logic [1:0]  i_ResultSrc_M;
    logic        i_MemWrite_M;
    logic        o_Stall_M;
    logic        o_MemExc_M;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic [31:0] o_ALU_Res_W;
    logic [31:0] o_ReadData_W;
    logic [4:0]  o_Rd_W;
    logic [31:0] o_PCPlus4_W;
    logic        o_RegWrite_W;
    logic [1:0]  o_ResultSrc_W;

    int n_checks;
    int n_fail;

    mem_stage_lsu dut (
        .clk           (clk),
        .rst           (rst),
        .i_ALU_Res_M   (i_ALU_Res_M),
        .i_WriteData_M (i_WriteData_M),
        .i_Rd_M        (i_Rd_M),
        .i_PCPlus4_M   (i_PCPlus4_M),
        .i_Funct3_M    (i_Funct3_M),
        .i_RegWrite_M  (i_RegWrite_M),
        .i_ResultSrc_M (i_ResultSrc_M),
        .i_MemWrite_M  (i_MemWrite_M),
        .o_Stall_M     (o_Stall_M),
        .o_MemExc_M    (o_MemExc_M),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_we     (o_dmem_we),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wdata  (o_dmem_wdata),
        .o_dmem_be     (o_dmem_be),
        .i_dmem_gnt    (i_dmem_gnt),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata),
        .o_ALU_Res_W   (o_ALU_Res_W),
        .o_ReadData_W  (o_ReadData_W),
        .o_Rd_W        (o_Rd_W),
        .o_PCPlus4_W   (o_PCPlus4_W),
        .o_RegWrite_W  (o_RegWrite_W),
        .o_ResultSrc_W (o_ResultSrc_W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] alu, input logic [31:0] rdat,
                         input logic [4:0] rd, input logic [31:0] pc, input logic rw,
                         input logic [1:0] rs);
        chk({tag, ".alu_w"}, o_ALU_Res_W, alu);
        chk({tag, ".rdata_w"}, o_ReadData_W, rdat);
        chk({tag, ".rd_w"}, {27'd0, o_Rd_W}, {27'd0, rd});
        chk({tag, ".pc_w"}, o_PCPlus4_W, pc);
        chk({tag, ".regwrite_w"}, {31'd0, o_RegWrite_W}, {31'd0, rw});
        chk({tag, ".rsrc_w"}, {30'd0, o_ResultSrc_W}, {30'd0, rs});
    endtask

    // Reference load result: select the addressed unit arithmetically, then extend.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        longint v;
        case (f3)
            3'b000, 3'b100: begin
                v = (rdata >> (8 * addr[1:0])) & 32'hFF;
                if (f3 == 3'b000 && v >= 128) v = v - 256;
            end
            3'b001, 3'b101: begin
                v = (rdata >> (addr[1] ? 16 : 0)) & 32'hFFFF;
                if (f3 == 3'b001 && v >= 32768) v = v - 65536;
            end
            default: v = rdata;
        endcase
        return v[31:0];
    endfunction

    // One instruction through MEM; called at posedge+1 and returns at posedge+1.
    task automatic do_op(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [2:0] f3, input logic regw,
                         input logic [1:0] rsrc, input logic mw, input int gnt_dly,
                         input int rv_dly, input logic [31:0] rdata);
        logic st, ld, legal_f3, exc;
        int size;
        logic [31:0] exp_be, exp_wdata;
        st = mw;
        ld = !mw && (rsrc == 2'b01);
        legal_f3 = st ? (f3 inside {3'b000, 3'b001, 3'b010})
                      : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        size = 1 << f3[1:0];
        exc = (st || ld) && (!legal_f3 || (alu % size) != 0);
        exp_be = 32'hF;
        exp_wdata = wd;
        if (st && f3 == 3'b000) begin
            exp_be = 32'h1 << alu[1:0];
            exp_wdata = (wd & 32'hFF) * 32'h01010101;
        end else if (st && f3 == 3'b001) begin
            exp_be = 32'h3 << alu[1:0];
            exp_wdata = (wd & 32'hFFFF) * 32'h00010001;
        end

        i_ALU_Res_M = alu; i_WriteData_M = wd; i_Rd_M = rd; i_PCPlus4_M = pc;
        i_Funct3_M = f3; i_RegWrite_M = regw; i_ResultSrc_M = rsrc; i_MemWrite_M = mw;
        i_dmem_gnt = 1'($urandom); i_dmem_rvalid = 1'($urandom); i_dmem_rdata = $urandom;

        if (!(st || ld) || exc) begin
            @(negedge clk);
            chk("nomem.req", {31'd0, o_dmem_req}, 32'd0);
            chk("nomem.stall", {31'd0, o_Stall_M}, 32'd0);
            chk("nomem.exc", {31'd0, o_MemExc_M}, {31'd0, exc});
            @(posedge clk); #1;
            chk_w("nomem", alu, 32'd0, rd, pc, regw && !exc, rsrc);
            return;
        end

        for (int i = 0; i <= gnt_dly; i++) begin
            i_dmem_gnt = (i == gnt_dly);
            i_dmem_rvalid = 1'($urandom);
            @(negedge clk);
            chk("req.req", {31'd0, o_dmem_req}, 32'd1);
            chk("req.exc", {31'd0, o_MemExc_M}, 32'd0);
            chk("req.addr", o_dmem_addr, alu & 32'hFFFF_FFFC);
            chk("req.we", {31'd0, o_dmem_we}, {31'd0, st});
            chk("req.be", {28'd0, o_dmem_be}, exp_be);
            if (st) chk("req.wdata", o_dmem_wdata, exp_wdata);
            chk("req.stall", {31'd0, o_Stall_M}, (st && i == gnt_dly) ? 32'd0 : 32'd1);
            @(posedge clk); #1;
            if (st && i == gnt_dly) chk_w("store", alu, 32'd0, rd, pc, regw, rsrc);
            else chk_w("reqbubble", 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 2'd0);
        end
        i_dmem_gnt = 1'b0;
        if (st) return;

        for (int i = 1; i <= rv_dly; i++) begin
            i_dmem_gnt = 1'($urandom);
            i_dmem_rvalid = (i == rv_dly);
            i_dmem_rdata = (i == rv_dly) ? rdata : $urandom;
            @(negedge clk);
            chk("resp.req", {31'd0, o_dmem_req}, 32'd0);
            chk("resp.stall", {31'd0, o_Stall_M}, (i == rv_dly) ? 32'd0 : 32'd1);
            @(posedge clk); #1;
            if (i == rv_dly) chk_w("load", alu, model_load(f3, alu, rdata), rd, pc, regw, rsrc);
            else chk_w("respbubble", 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 2'd0);
        end
        i_dmem_gnt = 1'b0;
        i_dmem_rvalid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b0;
        i_ALU_Res_M = 0; i_WriteData_M = 0; i_Rd_M = 0; i_PCPlus4_M = 0; i_Funct3_M = 0;
        i_RegWrite_M = 0; i_ResultSrc_M = 0; i_MemWrite_M = 0;
        i_dmem_gnt = 0; i_dmem_rvalid = 0; i_dmem_rdata = 0;
        #1;
        chk("rst.stall", {31'd0, o_Stall_M}, 32'd0);
        chk("rst.req", {31'd0, o_dmem_req}, 32'd0);
        chk("rst.be", {28'd0, o_dmem_be}, 32'd0);
        chk_w("rst", 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 2'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // SW, LB, LHU with delayed gnt/rvalid, exceptions, SB.
        do_op(32'h100, 32'hDEADBEEF, 5'd3, 32'h1004, 3'b010, 1'b0, 2'b00, 1'b1, 0, 1, 32'h0);
        do_op(32'h203, 32'h0, 5'd7, 32'h2004, 3'b000, 1'b1, 2'b01, 1'b0, 0, 1, 32'h80FFFFFF);
        chk("lb.value", o_ReadData_W, 32'hFFFFFF80);
        do_op(32'h302, 32'h0, 5'd9, 32'h3004, 3'b101, 1'b1, 2'b01, 1'b0, 2, 3, 32'hABCD1234);
        chk("lhu.value", o_ReadData_W, 32'h0000ABCD);
        do_op(32'h401, 32'h0, 5'd1, 32'h4004, 3'b001, 1'b0, 2'b00, 1'b1, 0, 1, 32'h0);
        do_op(32'h402, 32'h0, 5'd2, 32'h4008, 3'b010, 1'b1, 2'b01, 1'b0, 0, 1, 32'h0);
        do_op(32'h404, 32'h0, 5'd2, 32'h400C, 3'b011, 1'b1, 2'b01, 1'b0, 0, 1, 32'h0);
        do_op(32'h502, 32'h12, 5'd4, 32'h5004, 3'b000, 1'b0, 2'b00, 1'b1, 1, 1, 32'h0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] alu;
            logic [2:0]  f3;
            logic [1:0]  rsrc;
            logic        mw;
            int          kind;
            kind = $urandom_range(0, 2);
            alu = $urandom;
            f3 = 3'($urandom);
            if (kind != 0 && $urandom_range(0, 3) != 0)
                f3 = (kind == 2) ? 3'($urandom_range(0, 2))
                                 : ($urandom_range(0, 1) ? 3'($urandom_range(0, 2))
                                                         : 3'($urandom_range(4, 5)));
            if ($urandom_range(0, 1) != 0) alu[1:0] = (f3[1:0] == 2'b00) ? alu[1:0]
                                                    : (f3[1:0] == 2'b01) ? {alu[1], 1'b0} : 2'b00;
            mw = (kind == 2);
            rsrc = (kind == 1) ? 2'b01 : (kind == 2) ? 2'($urandom) : 2'($urandom_range(2, 3));
            if (kind == 0 && $urandom_range(0, 3) == 0) rsrc = 2'b00;
            do_op(alu, $urandom, 5'($urandom), $urandom, f3, 1'($urandom), rsrc, mw,
                  $urandom_range(0, 2), $urandom_range(1, 3), $urandom);
        end

        // Reset while waiting for a load response; the late rvalid must be ignored.
        i_ALU_Res_M = 32'h600; i_Funct3_M = 3'b010; i_ResultSrc_M = 2'b01; i_MemWrite_M = 1'b0;
        i_RegWrite_M = 1'b1; i_Rd_M = 5'd5; i_PCPlus4_M = 32'h6004;
        i_dmem_gnt = 1'b1; i_dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        i_dmem_gnt = 1'b0;
        @(negedge clk);
        chk("resp_pre_rst.stall", {31'd0, o_Stall_M}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("inrst.stall", {31'd0, o_Stall_M}, 32'd0);
        chk("inrst.req", {31'd0, o_dmem_req}, 32'd0);
        chk("inrst.be", {28'd0, o_dmem_be}, 32'd0);
        @(posedge clk); #1;
        chk_w("inrst", 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 2'd0);
        rst = 1'b1;
        i_ALU_Res_M = 32'h55; i_ResultSrc_M = 2'b00; i_Funct3_M = 3'b000; i_Rd_M = 5'd6;
        i_PCPlus4_M = 32'h6008; i_RegWrite_M = 1'b1;
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("postrst.stall", {31'd0, o_Stall_M}, 32'd0);
        chk("postrst.req", {31'd0, o_dmem_req}, 32'd0);
        @(posedge clk); #1;
        chk_w("postrst", 32'h55, 32'd0, 5'd6, 32'h6008, 1'b1, 2'b00);
        i_dmem_rvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-stage load/store unit. It consumes the EX/MEM pipeline register outputs and drives a req/gnt/rvalid data-memory port, performing store byte-lane steering and load extraction/extension. It stalls the front of the pipeline while an access is outstanding and contains the MEM/WB pipeline register feeding writeback.

Parameters:
DATA_W, 32, data/ALU result width (fixed 32; byte lanes assume 4)
PC_W, 32, PC+4 width
ADDR_W, 5, register-file address width
LOAD_SEL, 2'b01, ResultSrc encoding that marks a load

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
i_ALU_Res_M  in  DATA_W  effective address / ALU result
i_WriteData_M  in  DATA_W  store source data
i_Rd_M  in  ADDR_W  destination register
i_PCPlus4_M  in  PC_W  PC+4
i_Funct3_M  in  3  access size/sign
i_RegWrite_M  in  1  register write enable
i_ResultSrc_M  in  2  writeback mux select
i_MemWrite_M  in  1  store
o_Stall_M  out  1  hold IF/ID/EX and EX/MEM (to hazard unit)
o_MemExc_M  out  1  misaligned or illegal-size access, one-cycle pulse
o_dmem_req  out  1  memory request
o_dmem_we  out  1  write
o_dmem_addr  out  DATA_W  word-aligned address ({addr[31:2],2'b00})
o_dmem_wdata  out  DATA_W  lane-replicated store data
o_dmem_be  out  4  byte enables
i_dmem_gnt  in  1  request accepted this cycle
i_dmem_rvalid  in  1  read data valid
i_dmem_rdata  in  DATA_W  raw read word
o_ALU_Res_W, o_ReadData_W (DATA_W), o_Rd_W (ADDR_W), o_PCPlus4_W (PC_W), o_RegWrite_W (1), o_ResultSrc_W (2)  out  MEM/WB register

Behaviour:
- Classification: store = i_MemWrite_M; load = !i_MemWrite_M & i_ResultSrc_M==LOAD_SEL; mem_op = load|store.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Anything else is illegal.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- Illegal/misaligned mem_op: no request is issued; o_MemExc_M=1 for that cycle; no stall; MEM/WB captures with o_RegWrite_W=0.
- FSM states:
  - IDLE: o_dmem_req = legal mem_op. Store & gnt → completes this cycle (stall=0). Load & gnt → RESP. No gnt → stay in IDLE with request held (inputs held by stall).
  - RESP: req=0; stall=1 until i_dmem_rvalid. On rvalid: stall=0, WB captures extracted data, state → IDLE.
  - rvalid in IDLE is ignored.
- o_Stall_M = (IDLE & legal mem_op & !(store & gnt)) | (RESP & !rvalid).
  - Load minimum latency: 2 cycles in MEM (gnt in cycle 0, rvalid in cycle 1).
  - Store minimum latency: 1 cycle.
- Store steering:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wd[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{wd[15:0]}}.
  - SW: be=1111, wdata=wd.
  - o_dmem_we=store. Load: be=1111, we=0.
- Load extraction uses the byte/half selected by addr[1:0]/addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- MEM/WB register, each posedge:
  - stall=1: bubble, all W outputs 0.
  - otherwise: capture inputs; o_ReadData_W = extracted load data, 0 for non-loads.
  - Non-mem ops pass through in 1 cycle.
- Reset (any time, including in RESP): state=IDLE; all W outputs, o_Stall_M, o_MemExc_M, req, we, be = 0. A late rvalid after reset is ignored.

Decomposition:
- Shared package: funct3 load/store encodings, LOAD_SEL, FSM state enum {IDLE,RESP}.
- One natural sub-module, lsu_align: combinational store steering, load extract/extend, and misalign/illegal detection. The FSM and MEM/WB register stay in the top.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt same cycle → req=1, we=1, be=1111, addr=0x100, wdata=0xDEADBEEF; stall=0; next cycle W bubble-free with RegWrite_W=0.
- LB addr 0x203, rdata 0x80FFFFFF, gnt cycle 0, rvalid cycle 1 → stall high cycle 0 only; o_ReadData_W=0xFFFFFF80, RegWrite_W=1, Rd_W preserved.
- LHU addr 0x302, rdata 0xABCD1234, gnt delayed 2 cycles, rvalid 3 cycles after gnt → req held with stable addr 0x300; stall for 5 cycles; W outputs 0 during stall; final ReadData_W=0x0000ABCD.
- SH addr 0x401 → no req, MemExc_M=1 one cycle, stall=0; LW addr 0x402 → same; funct3=011 load → same.
- SB addr 0x502, data 0x12 → be=0100, wdata=0x12121212.
- Reset asserted in RESP, rvalid arrives after release → state IDLE, stall=0, W outputs 0, rvalid ignored. ADD result 0x55 (non-mem) → W captures next edge with ReadData_W=0.
